// File: rtl/gray_binary5_dec_if.sv
// Handshake bus for the bit-serial Gray-to-binary decoder: input word in,
// decoded word with adjacency flag and handshake count out.
interface gray_binary5_dec_if #(
  parameter int WIDTH = 5
);
  logic             in_valid;
  logic [WIDTH-1:0] gray_in;
  logic             in_ready;
  logic [WIDTH-1:0] bin_out;
  logic             out_valid;
  logic             out_ready;
  logic             adj_err;
  logic [7:0]       word_cnt;

  modport master (
    output in_valid, gray_in, out_ready,
    input  in_ready, bin_out, out_valid, adj_err, word_cnt
  );

  modport slave (
    input  in_valid, gray_in, out_ready,
    output in_ready, bin_out, out_valid, adj_err, word_cnt
  );
endinterface

// File: rtl/gray_binary5_dec.sv
// Bit-serial Gray-to-binary decoder, MSB first, one bit per cycle, with a
// Gray-adjacency check against the previously delivered code.
module gray_binary5_dec #(
  parameter int WIDTH = 5
) (
  input logic               clk,
  input logic               rst,
  gray_binary5_dec_if.slave bus
);
  localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CNT_W-1:0] CNT_TOP = CNT_W'(WIDTH - 1);

  typedef enum logic [1:0] {IDLE, CONV, DONE} state_t;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q;
  logic [WIDTH-1:0] gray_q;
  logic [WIDTH-1:0] bin_acc_q;
  logic [WIDTH-1:0] bin_q;
  logic [WIDTH-1:0] prev_gray_q;
  logic             carry_q;
  logic             have_prev_q;
  logic             adj_err_q;
  logic [7:0]       word_cnt_q;
  logic             dec_bit;
  logic [WIDTH-1:0] bin_nxt;

  // Adjacent Gray codes differ in exactly one bit; no reference means no error.
  function automatic logic not_adjacent(input logic [WIDTH-1:0] a,
                                        input logic [WIDTH-1:0] b,
                                        input logic             ref_ok);
    return ref_ok && ($countones(a ^ b) != 1);
  endfunction

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (bus.in_valid)  state_d = CONV;
      CONV:    if (cnt_q == '0)   state_d = DONE;
      DONE:    if (bus.out_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Running binary bit: b[i] = b[i+1] ^ g[i], with carry cleared for the MSB.
  always_comb begin
    dec_bit          = carry_q ^ gray_q[cnt_q];
    bin_nxt          = bin_acc_q;
    bin_nxt[cnt_q]   = dec_bit;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q       <= CNT_TOP;
      gray_q      <= '0;
      bin_acc_q   <= '0;
      bin_q       <= '0;
      prev_gray_q <= '0;
      carry_q     <= 1'b0;
      have_prev_q <= 1'b0;
      adj_err_q   <= 1'b0;
      word_cnt_q  <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (bus.in_valid) begin
            gray_q  <= bus.gray_in;
            cnt_q   <= CNT_TOP;
            carry_q <= 1'b0;
          end
        end
        CONV: begin
          carry_q   <= dec_bit;
          bin_acc_q <= bin_nxt;
          if (cnt_q == '0) begin
            // Publish only the finished word so bin_out never shows partial state.
            bin_q     <= bin_nxt;
            adj_err_q <= not_adjacent(gray_q, prev_gray_q, have_prev_q);
          end else begin
            cnt_q <= cnt_q - 1'b1;
          end
        end
        DONE: begin
          if (bus.out_ready) begin
            word_cnt_q  <= word_cnt_q + 8'd1;
            prev_gray_q <= gray_q;
            have_prev_q <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.in_ready  = (state_q == IDLE);
  assign bus.out_valid = (state_q == DONE);
  assign bus.bin_out   = bin_q;
  assign bus.adj_err   = adj_err_q;
  assign bus.word_cnt  = word_cnt_q;
endmodule

// File: tb/tb_gray_binary5_dec.sv
// Directed plus randomized bench for gray_binary5_dec against a table-driven
// Gray reference model with adjacency and handshake-count tracking.
module tb_gray_binary5_dec;
  localparam int W = 5;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   total = 0;
  int   bad   = 0;

  gray_binary5_dec_if #(.WIDTH(W)) bus ();
  gray_binary5_dec #(.WIDTH(W)) dut (.clk(clk), .rst(rst), .bus(bus));

  always #5 clk = ~clk;

  logic [W-1:0] inv_tbl [32];
  logic         m_have_prev;
  logic [W-1:0] m_prev_g;
  logic [W-1:0] m_last_bin;
  int           m_cnt;

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_have_prev = 1'b0;
    m_prev_g    = '0;
    m_last_bin  = '0;
    m_cnt       = 0;
  endtask

  // One full transaction: accept, watch conversion, optional backpressure, release.
  task automatic run_word(input logic [W-1:0] g, input int hold);
    int           n;
    logic [W-1:0] eb;
    logic         ea;
    n = 0;
    while (!bus.in_ready && n < 50) begin
      @(posedge clk); #1; n++;
    end
    check("in_ready_before_accept", bus.in_ready, 1);
    bus.gray_in  = g;
    bus.in_valid = 1'b1;
    @(posedge clk); #1;
    bus.in_valid  = 1'($urandom_range(0, 1));
    bus.gray_in   = W'($urandom);
    bus.out_ready = 1'($urandom_range(0, 1));
    eb = inv_tbl[g];
    ea = m_have_prev && ($countones(g ^ m_prev_g) != 1);
    n = 0;
    while (!bus.out_valid && n < 20) begin
      check("conv_bin_hold", bus.bin_out, m_last_bin);
      check("conv_in_ready", bus.in_ready, 0);
      @(posedge clk); #1; n++;
    end
    bus.out_ready = 1'b0;
    check("latency", n, W);
    check("bin_out", bus.bin_out, eb);
    check("adj_err", bus.adj_err, ea);
    check("word_cnt_done", bus.word_cnt, m_cnt);
    repeat (hold) begin
      bus.in_valid = 1'b1;
      bus.gray_in  = W'($urandom);
      @(posedge clk); #1;
      check("bp_out_valid", bus.out_valid, 1);
      check("bp_in_ready", bus.in_ready, 0);
      check("bp_bin_out", bus.bin_out, eb);
      check("bp_adj_err", bus.adj_err, ea);
      check("bp_word_cnt", bus.word_cnt, m_cnt);
    end
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    @(posedge clk); #1;
    bus.out_ready = 1'b0;
    m_cnt       = (m_cnt + 1) % 256;
    m_have_prev = 1'b1;
    m_prev_g    = g;
    m_last_bin  = eb;
    check("release_out_valid", bus.out_valid, 0);
    check("release_in_ready", bus.in_ready, 1);
    check("release_word_cnt", bus.word_cnt, m_cnt);
    check("release_bin_hold", bus.bin_out, eb);
  endtask

  initial begin
    logic [W-1:0] g;
    // Reference table: inverse of the encoding b ^ (b >> 1).
    for (int b = 0; b < 32; b++) begin
      g = W'(b ^ (b >> 1));
      inv_tbl[g] = W'(b);
    end
    model_reset();
    bus.in_valid  = 1'b0;
    bus.gray_in   = '0;
    bus.out_ready = 1'b0;
    #1;
    check("rst_in_ready", bus.in_ready, 1);
    check("rst_out_valid", bus.out_valid, 0);
    check("rst_bin_out", bus.bin_out, 0);
    check("rst_adj_err", bus.adj_err, 0);
    check("rst_word_cnt", bus.word_cnt, 0);
    @(negedge clk); rst = 1'b0;
    @(posedge clk); #1;

    run_word(5'b11001, 0);
    check("basic_bin", m_last_bin, 5'b10001);
    run_word(5'b00000, 0);
    run_word(5'b10000, 0);
    run_word(5'b11111, 0);
    run_word(5'b11001, 0);
    run_word(5'b11000, 0);
    run_word(5'b00000, 0);
    run_word(5'b00000, 0);
    run_word(5'b01101, 3);

    // Reset two cycles into a conversion, off the clock edge.
    bus.gray_in  = 5'b10110;
    bus.in_valid = 1'b1;
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    @(posedge clk); @(posedge clk); #3;
    rst = 1'b1;
    #1;
    model_reset();
    check("mid_rst_out_valid", bus.out_valid, 0);
    check("mid_rst_in_ready", bus.in_ready, 1);
    check("mid_rst_word_cnt", bus.word_cnt, 0);
    check("mid_rst_bin_out", bus.bin_out, 0);
    @(negedge clk); rst = 1'b0;
    @(posedge clk); #1;
    run_word(5'b00111, 0);

    // Exhaustive sweep, then random/adjacent codes, for 255 more handshakes.
    for (int i = 0; i < 255; i++) begin
      if (i < 32)                      g = W'(i);
      else if ($urandom_range(0, 1))   g = m_prev_g ^ W'(1 << $urandom_range(0, W - 1));
      else                             g = W'($urandom);
      run_word(g, $urandom_range(0, 2));
    end
    check("wrap_word_cnt", bus.word_cnt, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
